result_lcd_writer: RTL and testbench

Display back-end for the exponent FSMD. Takes the 6-bit result the datapath latches into its output register and renders it on a pre-initialised HD44780-style character LCD as two decimal characters at a fixed DDRAM address. It converts binary to decimal sequentially, then issues three timed LCD bus writes: address command, tens digit, ones digit. It reports busy and completion to the control FSM.

---
 rtl/result_lcd_writer_if.sv | 19 +
 rtl/result_lcd_writer.sv | 103 ++++++++++
 tb/tb_result_lcd_writer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/result_lcd_writer_if.sv
// result_lcd_writer_if: load/status handshake and HD44780 write bus of the result display back-end
interface result_lcd_writer_if;
    logic [5:0] result_i;
    logic       load_i;
    logic       busy_o;
    logic       done_o;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;
    modport master (
        output result_i, load_i,
        input  busy_o, done_o, lcd_rs, lcd_rw, lcd_e, lcd_data
    );
    modport slave (
        input  result_i, load_i,
        output busy_o, done_o, lcd_rs, lcd_rw, lcd_e, lcd_data
    );
endinterface

// File: rtl/result_lcd_writer.sv
// result_lcd_writer: converts a 6-bit result to two decimal chars and writes them to an HD44780 LCD
module result_lcd_writer #(
    parameter logic [6:0]  DDRAM_ADDR   = 7'h00,
    parameter int unsigned E_PULSE_CYC  = 12,
    parameter int unsigned CMD_WAIT_CYC = 2000
) (
    input logic               clk,
    input logic               rst,
    result_lcd_writer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CONV, SETUP, PULSE, WAIT, DONE} state_t;
    localparam logic [15:0] E_LOAD = 16'(E_PULSE_CYC - 1);
    localparam logic [15:0] W_LOAD = 16'(CMD_WAIT_CYC - 1);
    state_t      state_q, state_d;
    logic [5:0]  rem_q, rem_d;
    logic [2:0]  tens_q, tens_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rs_q, rs_d, e_q, e_d, busy_q, busy_d, done_q, done_d;
    logic [7:0]  data_q, data_d;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            tens_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            tens_q  <= tens_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            e_q     <= e_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        tens_d  = tens_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.load_i) begin
                state_d = CONV;
                rem_d   = bus.result_i;
                tens_d  = '0;
                idx_d   = '0;
            end
            CONV: if (rem_q >= 6'd10) begin
                rem_d  = rem_q - 6'd10;
                tens_d = tens_q + 3'd1;
            end else begin
                state_d = SETUP;
            end
            SETUP: begin
                state_d = PULSE;
                cnt_d   = E_LOAD;
            end
            PULSE: if (cnt_q == '0) begin
                state_d = WAIT;
                cnt_d   = W_LOAD;
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
            WAIT: if (cnt_q != '0) begin
                cnt_d = cnt_q - 16'd1;
            end else if (idx_q < 2'd2) begin
                state_d = SETUP;
                idx_d   = idx_q + 2'd1;
            end else begin
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    // Outputs are registered from the next state so lcd_e cannot glitch; the bus byte only changes on SETUP entry.
    always_comb begin
        e_d    = state_d == PULSE;
        busy_d = state_d inside {CONV, SETUP, PULSE, WAIT};
        done_d = state_d == DONE;
        rs_d   = state_d == SETUP ? idx_d != 2'd0 : rs_q;
        data_d = state_d != SETUP ? data_q :
                 idx_d == 2'd0    ? 8'h80 | {1'b0, DDRAM_ADDR} :
                 idx_d == 2'd1    ? (tens_q == 3'd0 ? 8'h20 : 8'h30 + {5'd0, tens_q}) :
                                    8'h30 + {2'd0, rem_q};
    end
    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.lcd_rs   = rs_q;
    assign bus.lcd_rw   = 1'b0;
    assign bus.lcd_e    = e_q;
    assign bus.lcd_data = data_q;
endmodule

// File: tb/tb_result_lcd_writer.sv
// tb_result_lcd_writer: table-driven and scoreboarded bench for result_lcd_writer with E=2, W=3
module tb_result_lcd_writer;
    typedef struct {
        logic [5:0] r;
        logic [7:0] tens_b;
        logic [7:0] ones_b;
        int         lat;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    result_lcd_writer_if a ();
    result_lcd_writer_if b ();
    result_lcd_writer #(.DDRAM_ADDR(7'h00), .E_PULSE_CYC(2), .CMD_WAIT_CYC(3)) dut0 (
        .clk(clk), .rst(rst), .bus(a.slave));
    result_lcd_writer #(.DDRAM_ADDR(7'h40), .E_PULSE_CYC(2), .CMD_WAIT_CYC(3)) dut1 (
        .clk(clk), .rst(rst), .bus(b.slave));
    int n_cmp = 0;
    int n_bad = 0;
    logic [8:0] exp_q[$];
    vec_t tbl[6];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask
    task automatic watch_quiet(input int cycles);
        int extra;
        logic pe;
        extra = 0;
        pe = a.lcd_e;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (a.done_o || (a.lcd_e && !pe)) extra++;
            pe = a.lcd_e;
        end
        chk("idle_quiet", extra, 0);
    endtask
    task automatic run_a(input logic [5:0] r, input logic [7:0] tens_b, input logic [7:0] ones_b,
                         input int lat, input bit hold, input bit abort);
        logic pe;
        logic [8:0] cur;
        int hi, lo, wr;
        bit fin;
        exp_q.push_back(9'h080);
        exp_q.push_back({1'b1, tens_b});
        exp_q.push_back({1'b1, ones_b});
        pe = 1'b0;
        cur = '0;
        hi = 0;
        lo = -1;
        wr = 0;
        fin = 1'b0;
        a.result_i = r;
        a.load_i = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) a.load_i = 1'b0;
        for (int t = 0; t <= lat + 4 && !fin; t++) begin
            if (a.done_o) begin
                chk("latency", t, lat);
                chk("busy_at_done", a.busy_o, 0);
                chk("writes", wr, 3);
                chk("tail_low", lo, 3);
                fin = 1'b1;
            end else begin
                if (t == 1) chk("busy", a.busy_o, 1);
                if (hold && t == 2) a.result_i = r ^ 6'h3f;
                if (a.lcd_e && !pe) begin
                    cur = {a.lcd_rs, a.lcd_data};
                    if (wr > 0) chk("e_low", lo, 4);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL write: got %0h, want none", cur);
                    end else begin
                        chk("write", cur, exp_q.pop_front());
                    end
                    wr++;
                    hi = 0;
                    lo = -1;
                    if (abort && wr == 2) begin
                        rst = 1'b0;
                        @(posedge clk);
                        #1;
                        chk("abort_e", a.lcd_e, 0);
                        chk("abort_busy", a.busy_o, 0);
                        chk("abort_data", a.lcd_data, 8'h00);
                        chk("abort_rs", a.lcd_rs, 0);
                        chk("abort_done", a.done_o, 0);
                        rst = 1'b1;
                        exp_q.delete();
                        watch_quiet(40);
                        return;
                    end
                end
                if (a.lcd_e) begin
                    hi++;
                    chk("data_hold", {a.lcd_rs, a.lcd_data}, cur);
                end
                if (!a.lcd_e && pe) begin
                    chk("e_high", hi, 2);
                    lo = 0;
                end
                if (!a.lcd_e && lo >= 0) lo++;
                pe = a.lcd_e;
                @(posedge clk);
                #1;
            end
        end
        if (!fin) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: result %0d got no done_o, want one within %0d cycles", r, lat);
        end
        @(posedge clk);
        #1;
        a.load_i = 1'b0;
        chk("done_pulse", a.done_o, 0);
        watch_quiet(20);
        chk("queue_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask
    initial begin
        bit seen;
        tbl[0] = '{6'd45, 8'h34, 8'h35, 23};
        tbl[1] = '{6'd7,  8'h20, 8'h37, 19};
        tbl[2] = '{6'd0,  8'h20, 8'h30, 19};
        tbl[3] = '{6'd63, 8'h36, 8'h33, 25};
        tbl[4] = '{6'd10, 8'h31, 8'h30, 20};
        tbl[5] = '{6'd21, 8'h32, 8'h31, 21};
        a.load_i = 1'b0;
        a.result_i = '0;
        b.load_i = 1'b0;
        b.result_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", a.busy_o, 0);
        chk("rst_done", a.done_o, 0);
        chk("rst_e", a.lcd_e, 0);
        chk("rst_rs", a.lcd_rs, 0);
        chk("rst_rw", a.lcd_rw, 0);
        chk("rst_data", a.lcd_data, 8'h00);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) run_a(tbl[i].r, tbl[i].tens_b, tbl[i].ones_b, tbl[i].lat, 1'b0, 1'b0);
        run_a(6'd45, 8'h34, 8'h35, 23, 1'b1, 1'b0);
        run_a(6'd45, 8'h34, 8'h35, 23, 1'b0, 1'b1);
        run_a(tbl[5].r, tbl[5].tens_b, tbl[5].ones_b, tbl[5].lat, 1'b0, 1'b0);
        b.result_i = 6'd9;
        b.load_i = 1'b1;
        @(posedge clk);
        #1;
        b.load_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (b.lcd_e) begin
                seen = 1'b1;
                chk("addr_rs", b.lcd_rs, 0);
                chk("addr_byte", b.lcd_data, 8'hC0);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        chk("addr_seen", seen, 1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (b.done_o) begin
                seen = 1'b1;
                chk("addr_ones", b.lcd_data, 8'h39);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        chk("addr_done", seen, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
